// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: word width, vector length, PISO state encoding.
`timescale 1ns/1ps
package cnn_pkg;

   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned VEC_LEN    = 4;
   localparam int unsigned CNT_W      = $clog2(VEC_LEN);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   typedef enum logic {
      StIdle  = ST_IDLE,
      StShift = ST_SHIFT
   } state_e;

   typedef logic [CNT_W-1:0] cnt_t;

   // Count value at which the final word (in0) is being emitted.
   localparam cnt_t CNT_LAST = cnt_t'(VEC_LEN - 1);

endpackage

// File: rtl/piso_shift4.sv
// 4-word parallel-in/serial-out shifter, emits in3..in0 with downstream pause.
// Define PISO_BACK2BACK_EN to accept the next vector on the last beat (no idle bubble).
`timescale 1ns/1ps
module piso_shift4
   import cnn_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in0_i,
   input  logic [WIDTH-1:0] in1_i,
   input  logic [WIDTH-1:0] in2_i,
   input  logic [WIDTH-1:0] in3_i,
   output logic [WIDTH-1:0] out_o,
   output logic             out_valid_o,
   output logic             out_last_o,
   input  logic             pause_i
);

   state_e           state_q;
   cnt_t             cnt_q;
   logic [WIDTH-1:0] cap0_q, cap1_q, cap2_q;
   logic [WIDTH-1:0] out_q;
   logic             out_valid_q;
   logic             out_last_q;

   logic             accept;
   logic             advance;
   logic [WIDTH-1:0] next_word;

`ifdef PISO_BACK2BACK_EN
   assign in_ready_o = !clear_i &&
                       ((state_q == StIdle) ||
                        ((state_q == StShift) && out_last_q && !pause_i));
`else
   assign in_ready_o = !clear_i && (state_q == StIdle);
`endif

   assign accept  = in_valid_i && in_ready_o;
   assign advance = (state_q == StShift) && !pause_i;

   // cnt holds the number of words already emitted, so it selects the next one.
   always_comb begin
      next_word = cap0_q;
      unique case (cnt_q)
         cnt_t'(1): next_word = cap2_q;
         cnt_t'(2): next_word = cap1_q;
         default:   next_word = cap0_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         cap0_q      <= '0;
         cap1_q      <= '0;
         cap2_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (clear_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (accept) begin
         state_q     <= StShift;
         cnt_q       <= cnt_t'(1);
         cap0_q      <= in0_i;
         cap1_q      <= in1_i;
         cap2_q      <= in2_i;
         out_q       <= in3_i;
         out_valid_q <= 1'b1;
         out_last_q  <= 1'b0;
      end else if (advance) begin
         if (out_last_q) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end else begin
            out_q      <= next_word;
            out_last_q <= (cnt_q == CNT_LAST);
            // Saturate on the last word rather than wrapping.
            cnt_q      <= (cnt_q == CNT_LAST) ? cnt_q : cnt_q + cnt_t'(1);
         end
      end
   end

   assign out_o       = out_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_piso_shift4.sv
// Scoreboard bench for piso_shift4: queue of expected beats plus loopback shifter model.
`timescale 1ns/1ps
module tb_piso_shift4;
   import cnn_pkg::*;

   localparam int unsigned W = DATA_WIDTH;
`ifdef PISO_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   typedef logic [3:0][W-1:0] vec_t;
   typedef struct {
      logic [W-1:0] word;
      logic         last;
      vec_t         vec;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clear, in_valid, in_ready, pause;
   logic [W-1:0] in0, in1, in2, in3;
   logic [W-1:0] out;
   logic         out_valid, out_last;

   beat_t        sb[$];
   beat_t        mon_e;
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] last_seen;
   logic [W-1:0] sr [4];

   piso_shift4 #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in0_i       (in0),
      .in1_i       (in1),
      .in2_i       (in2),
      .in3_i       (in3),
      .out_o       (out),
      .out_valid_o (out_valid),
      .out_last_o  (out_last),
      .pause_i     (pause)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < 4; i++) v[i] = W'($urandom);
      return v;
   endfunction

   // Monitor: the front of the scoreboard is the beat the DUT should be presenting.
   always @(negedge clk) begin
      if (rst_n) begin
         check("out_valid", out_valid, sb.size() != 0);
         if (!out_valid) begin
            check("out_hold", out, last_seen);
            check("out_last_idle", out_last, 1'b0);
         end else if (sb.size() != 0) begin
            last_seen = sb[0].word;
            check("out_word", out, sb[0].word);
            check("out_last", out_last, sb[0].last);
            if (!pause) begin
               mon_e = sb.pop_front();
               sr[3] = sr[2];
               sr[2] = sr[1];
               sr[1] = sr[0];
               sr[0] = out;
               if (mon_e.last)
                  for (int i = 0; i < 4; i++) check("loopback", sr[i], mon_e.vec[i]);
            end
         end
      end
   end

   // One clock of stimulus; the model decides readiness from the pending beat count.
   task automatic cyc(input logic clr, input logic iv, input logic pz, input vec_t v,
                      output logic acc);
      logic exp_ready;
      @(posedge clk);
      #1;
      clear    = clr;
      in_valid = iv;
      pause    = pz;
      in0 = v[0]; in1 = v[1]; in2 = v[2]; in3 = v[3];
      #2;
      exp_ready = !clr && ((sb.size() == 0) ||
                           (B2B && (sb.size() == 1) && !pz));
      check("in_ready", in_ready, exp_ready);
      acc = iv && exp_ready;
      @(negedge clk);
      #1;
      if (clr) sb.delete();
      if (acc) begin
         for (int k = 3; k >= 0; k--) begin
            beat_t b;
            b.word = v[k];
            b.last = (k == 0);
            b.vec  = v;
            sb.push_back(b);
         end
      end
   endtask

   task automatic idle(input int n);
      logic a;
      repeat (n) cyc(1'b0, 1'b0, 1'b0, '0, a);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      clear    = 1'b0;
      pause    = 1'b0;
      #1;
      check("rst_out", out, '0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_last", out_last, 1'b0);
      sb.delete();
      last_seen = '0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      check("rst_ready", in_ready, 1'b1);
   endtask

   initial begin
      logic a;
      vec_t v;
      int   n_acc, start, span;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; pause = 1'b0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      last_seen = '0;
      for (int i = 0; i < 4; i++) sr[i] = '0;
      #2;
      check("rst_out", out, '0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_last", out_last, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Directed vector, no pause.
      v = {16'h0033, 16'h0022, 16'h0011, 16'h0000};
      cyc(1'b0, 1'b1, 1'b0, v, a);
      idle(6);

      // Pause held 3 cycles on beat 2.
      cyc(1'b0, 1'b1, 1'b0, rand_vec(), a);
      cyc(1'b0, 1'b0, 1'b0, '0, a);
      repeat (3) cyc(1'b0, 1'b0, 1'b1, '0, a);
      idle(5);

      // Clear during beat 3 with in_valid high, then accept on the next cycle.
      cyc(1'b0, 1'b1, 1'b0, rand_vec(), a);
      idle(2);
      cyc(1'b1, 1'b1, 1'b0, rand_vec(), a);
      cyc(1'b0, 1'b1, 1'b0, rand_vec(), a);
      idle(6);

      // Reset during beat 2.
      cyc(1'b0, 1'b1, 1'b0, rand_vec(), a);
      cyc(1'b0, 1'b0, 1'b0, '0, a);
      do_reset();
      idle(3);

      // Pause on the last beat with in_valid held.
      cyc(1'b0, 1'b1, 1'b0, rand_vec(), a);
      idle(3);
      cyc(1'b0, 1'b1, 1'b1, rand_vec(), a);
      cyc(1'b0, 1'b1, 1'b0, rand_vec(), a);
      idle(10);

      // Back-to-back throughput: cycles from first to fourth accept.
      n_acc = 0; start = 0; span = 0;
      for (int c = 0; c < 40; c++) begin
         cyc(1'b0, 1'b1, 1'b0, rand_vec(), a);
         if (a) begin
            n_acc++;
            if (n_acc == 1) start = c;
            if (n_acc == 4) begin
               span = c - start;
               break;
            end
         end
      end
      check("b2b_span", span, B2B ? 12 : 15);
      idle(8);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = $urandom_range(0, 999);
         if (r < 3) do_reset();
         else cyc(r < 40, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), rand_vec(), a);
      end
      idle(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
